// File: rtl/blit_cmd_queue.sv
// Blitter command queue: a block-RAM FIFO followed by a prefetch register
// and an output register. The prefetch register doubles as the RAM's
// registered read port, so the RAM maps onto a synchronous-read block RAM.
// Capacity is DEPTH RAM entries plus the two stages.
module blit_cmd_queue #(
  parameter int CMD_WIDTH = 104,
  parameter int ADDR_BITS = 8,
  parameter int LOW_WATER = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [CMD_WIDTH-1:0] wr_cmd,
  input  logic                 wr_en,
  output logic [ADDR_BITS:0]   wr_slots_free,
  output logic                 wr_overflow,
  input  logic                 overflow_clear,
  input  logic                 flush,
  output logic                 space_irq,
  output logic [CMD_WIDTH-1:0] rd_cmd,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [15:0]          pop_count
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_C = (ADDR_BITS+1)'(DEPTH);
  // Threshold clamped to DEPTH+1 so it always fits one bit wider than the count.
  localparam int LW_CLAMP = (LOW_WATER > DEPTH + 1) ? DEPTH + 1 : LOW_WATER;
  localparam logic [ADDR_BITS+1:0] LW_C = (ADDR_BITS+2)'(LW_CLAMP);

  logic [CMD_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_BITS-1:0] wr_ptr_reg;
  logic [ADDR_BITS-1:0] rd_ptr_reg;
  logic [ADDR_BITS:0]   ram_count_reg;
  logic [ADDR_BITS:0]   ram_count_next;
  logic [CMD_WIDTH-1:0] pf_data_reg;
  logic                 pf_valid_reg;
  logic [CMD_WIDTH-1:0] rd_cmd_reg;
  logic                 rd_valid_reg;
  logic                 wr_overflow_reg;
  logic                 space_irq_reg;
  logic [15:0]          pop_count_reg;

  logic ram_full;
  logic ram_empty;
  logic do_pop;
  logic out_load;
  logic ram_rd;
  logic do_push;
  logic do_drop;

  // Handshake decode: the output stage pulls from prefetch, prefetch pulls from RAM.
  always_comb begin
    ram_full  = (ram_count_reg == DEPTH_C);
    ram_empty = (ram_count_reg == '0);
    do_pop    = rd_valid_reg && rd_ready;
    out_load  = pf_valid_reg && (!rd_valid_reg || do_pop);
    ram_rd    = !ram_empty && (!pf_valid_reg || out_load);
    do_push   = wr_en && !ram_full;
    do_drop   = wr_en && ram_full;
    ram_count_next = ram_count_reg;
    case ({do_push, ram_rd})
      2'b10:   ram_count_next = ram_count_reg + 1'b1;
      2'b01:   ram_count_next = ram_count_reg - 1'b1;
      default: ram_count_next = ram_count_reg;
    endcase
  end

  // RAM write port; pushes are suppressed while reset or flush is active.
  always_ff @(posedge clock) begin
    if (do_push && !flush && !reset) begin
      mem[wr_ptr_reg] <= wr_cmd;
    end
  end

  // RAM registered read port, which is also the prefetch data register.
  always_ff @(posedge clock) begin
    if (ram_rd) begin
      pf_data_reg <= mem[rd_ptr_reg];
    end
  end

  // Pointers, occupancy, stage valids, output data, flags and pop counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      ram_count_reg   <= '0;
      pf_valid_reg    <= 1'b0;
      rd_valid_reg    <= 1'b0;
      rd_cmd_reg      <= '0;
      wr_overflow_reg <= 1'b0;
      space_irq_reg   <= (LW_C != '0);
      pop_count_reg   <= '0;
    end else if (flush) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      ram_count_reg <= '0;
      pf_valid_reg  <= 1'b0;
      rd_valid_reg  <= 1'b0;
      space_irq_reg <= (LW_C != '0);
      pop_count_reg <= '0;
      // The overflow flag survives a flush; only an explicit clear drops it.
      if (overflow_clear) begin
        wr_overflow_reg <= 1'b0;
      end
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (ram_rd) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      ram_count_reg <= ram_count_next;
      space_irq_reg <= ({1'b0, ram_count_next} < LW_C);

      if (ram_rd) begin
        pf_valid_reg <= 1'b1;
      end else if (out_load) begin
        pf_valid_reg <= 1'b0;
      end

      if (out_load) begin
        rd_valid_reg <= 1'b1;
        rd_cmd_reg   <= pf_data_reg;
      end else if (do_pop) begin
        rd_valid_reg <= 1'b0;
      end

      if (do_pop) begin
        pop_count_reg <= pop_count_reg + 16'd1;
      end

      // A new drop wins over a same-cycle clear.
      if (do_drop) begin
        wr_overflow_reg <= 1'b1;
      end else if (overflow_clear) begin
        wr_overflow_reg <= 1'b0;
      end
    end
  end

  assign wr_slots_free = DEPTH_C - ram_count_reg;
  assign wr_overflow   = wr_overflow_reg;
  assign space_irq     = space_irq_reg;
  assign rd_cmd        = rd_cmd_reg;
  assign rd_valid      = rd_valid_reg;
  assign pop_count     = pop_count_reg;

endmodule

// File: tb/tb_blit_cmd_queue.sv
// Directed bench for blit_cmd_queue with a small expected-order queue.
module tb_blit_cmd_queue;

  localparam int CW    = 104;
  localparam int AB    = 4;
  localparam int LW    = 16;
  localparam int DEPTH = 16;

  logic          clock;
  logic          reset;
  logic [CW-1:0] wr_cmd;
  logic          wr_en;
  logic [AB:0]   wr_slots_free;
  logic          wr_overflow;
  logic          overflow_clear;
  logic          flush;
  logic          space_irq;
  logic [CW-1:0] rd_cmd;
  logic          rd_valid;
  logic          rd_ready;
  logic [15:0]   pop_count;

  blit_cmd_queue #(
    .CMD_WIDTH(CW),
    .ADDR_BITS(AB),
    .LOW_WATER(LW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .wr_cmd(wr_cmd),
    .wr_en(wr_en),
    .wr_slots_free(wr_slots_free),
    .wr_overflow(wr_overflow),
    .overflow_clear(overflow_clear),
    .flush(flush),
    .space_irq(space_irq),
    .rd_cmd(rd_cmd),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .pop_count(pop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int passed = 0;
  int total = 0;
  int cyc = 0;
  int first_pop = 0;
  int last_pop = 0;
  int npops = 0;
  logic [CW-1:0] exp_q[$];
  bit            prev_stall = 0;
  logic [CW-1:0] prev_cmd;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // One clock with the current inputs; checks any pop against the expected order
  // and that a stalled output held its command.
  task automatic cycle();
    logic [CW-1:0] e;
    if (prev_stall) begin
      check("stall_valid", rd_valid, 1);
      check("stall_hold", rd_cmd, prev_cmd);
    end
    prev_stall = rd_valid && !rd_ready;
    prev_cmd   = rd_cmd;
    if (rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("pop_data", rd_cmd, e);
      end
      if (npops == 0) first_pop = cyc;
      last_pop = cyc;
      npops++;
    end
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_en = 1'b0;
    flush = 1'b0;
    overflow_clear = 1'b0;
    rd_ready = 1'b0;
    wr_cmd = '0;
    tick();
    reset = 1'b0;
    exp_q.delete();
    prev_stall = 0;
    npops = 0;
  endtask

  task automatic push(input logic [CW-1:0] v, input bit accepted);
    wr_cmd = v;
    wr_en = 1'b1;
    if (accepted) exp_q.push_back(v);
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rd_ready = 1'b1;
    wr_en = 1'b0;
    while (exp_q.size() > 0 && n < 64) begin
      cycle();
      n++;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    logic [31:0] pat;
    reset = 1'b1;
    wr_en = 1'b0;
    flush = 1'b0;
    overflow_clear = 1'b0;
    rd_ready = 1'b0;
    wr_cmd = '0;

    // Reset state
    do_reset();
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_cmd", rd_cmd, 0);
    check("rst_slots", wr_slots_free, DEPTH);
    check("rst_irq", space_irq, 1);
    check("rst_ovf", wr_overflow, 0);
    check("rst_pop_count", pop_count, 0);
    $display("txn reset: slots=%0d irq=%0b", wr_slots_free, space_irq);

    // Single command latency
    rd_ready = 1'b1;
    wr_cmd = 104'hA5;
    wr_en = 1'b1;
    exp_q.push_back(104'hA5);
    cycle();
    wr_en = 1'b0;
    check("lat_after_e0", rd_valid, 0);
    cycle();
    check("lat_after_e1", rd_valid, 0);
    cycle();
    check("lat_after_e2_valid", rd_valid, 1);
    check("lat_after_e2_data", rd_cmd, 104'hA5);
    cycle();
    check("single_pop_count", pop_count, 1);
    check("single_valid_low", rd_valid, 0);
    $display("txn single: pop_count=%0d", pop_count);

    // Fill and overflow
    do_reset();
    rd_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      push(104'(200 + i), 1);
      if (i == 16) check("irq_count15", space_irq, 1);
      if (i == 17) check("irq_count16", space_irq, 0);
    end
    check("fill_slots", wr_slots_free, 0);
    check("fill_ovf", wr_overflow, 0);
    check("fill_head", rd_cmd, 200);
    push(104'd999, 0);
    check("ovf_set", wr_overflow, 1);
    overflow_clear = 1'b1;
    push(104'd998, 0);
    check("ovf_clear_vs_new", wr_overflow, 1);
    cycle();
    overflow_clear = 1'b0;
    check("ovf_cleared", wr_overflow, 0);
    $display("txn fill: slots=%0d ovf=%0b", wr_slots_free, wr_overflow);
    rd_ready = 1'b1;
    cycle();
    check("irq_drain15", space_irq, 1);
    check("drain_slots1", wr_slots_free, 1);
    drain();
    check("fill_drained_valid", rd_valid, 0);
    check("fill_pop_count", pop_count, 18);
    $display("txn fill_drain: pop_count=%0d", pop_count);

    // Streaming across pointer wrap
    do_reset();
    rd_ready = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      wr_cmd = 104'(i);
      wr_en = 1'b1;
      exp_q.push_back(104'(i));
      cycle();
    end
    wr_en = 1'b0;
    drain();
    check("stream_pop_count", pop_count, 100);
    check("stream_npops", npops, 100);
    check("stream_throughput", last_pop - first_pop, 99);
    check("stream_ovf", wr_overflow, 0);
    $display("txn stream: pops=%0d span=%0d", npops, last_pop - first_pop);

    // Backpressure with a fixed ready pattern
    do_reset();
    pat = 32'hB6DB6DB6;
    for (int i = 0; i < 30; i++) begin
      wr_cmd = 104'(32'h1000 + i * 7);
      wr_en = 1'b1;
      rd_ready = pat[i];
      exp_q.push_back(104'(32'h1000 + i * 7));
      cycle();
    end
    wr_en = 1'b0;
    drain();
    check("bp_pop_count", pop_count, 30);
    check("bp_ovf", wr_overflow, 0);
    $display("txn backpressure: pop_count=%0d", pop_count);

    // Flush with same-cycle push and pop, overflow flag preserved
    do_reset();
    rd_ready = 1'b0;
    for (int i = 0; i < 18; i++) push(104'(300 + i), 1);
    push(104'd399, 0);
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) cycle();
    check("pre_flush_pop_count", pop_count, 8);
    flush = 1'b1;
    wr_en = 1'b1;
    wr_cmd = 104'd555;
    rd_ready = 1'b1;
    tick();
    flush = 1'b0;
    wr_en = 1'b0;
    exp_q.delete();
    prev_stall = 0;
    check("flush_valid", rd_valid, 0);
    check("flush_slots", wr_slots_free, DEPTH);
    check("flush_pop_count", pop_count, 0);
    check("flush_ovf_kept", wr_overflow, 1);
    check("flush_irq", space_irq, 1);
    push(104'd77, 1);
    drain();
    check("post_flush_pop_count", pop_count, 1);
    $display("txn flush: pop_count=%0d ovf=%0b", pop_count, wr_overflow);

    // Reset mid-transfer overrides flush and everything else
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(104'(600 + i), 1);
    reset = 1'b1;
    flush = 1'b1;
    wr_en = 1'b1;
    overflow_clear = 1'b0;
    tick();
    reset = 1'b0;
    flush = 1'b0;
    wr_en = 1'b0;
    exp_q.delete();
    prev_stall = 0;
    rd_ready = 1'b1;
    tick();
    tick();
    tick();
    check("midrst_valid", rd_valid, 0);
    check("midrst_slots", wr_slots_free, DEPTH);
    check("midrst_ovf", wr_overflow, 0);
    check("midrst_pop_count", pop_count, 0);
    $display("txn mid_reset: slots=%0d", wr_slots_free);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
